// File: rtl/mem_sequencer.sv
// Memory access sequencer for a simple 8-bit CPU front end.
// Fetches an opcode and up to two operand bytes through the program-counter
// address path, then optionally performs one data access at the operand address.

package mem_sequencer_pkg;
  // Address source selector for the external memory mux.
  typedef enum logic {
    PC_ADDR = 1'b0,
    OP_ADDR = 1'b1
  } mm_t;
endpackage

module mem_sequencer
  import mem_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       wr,
  input  logic [7:0] rdata,
  output mm_t        mm,
  output logic       pc_inc,
  output logic [15:0] op_addr,
  output logic       mem_we,
  output logic [7:0] opcode,
  output logic [7:0] operand,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_OP = 3'd1,
    FETCH_LO = 3'd2,
    FETCH_HI = 3'd3,
    DATA     = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [1:0] MODE_IMPLIED   = 2'd0;
  localparam logic [1:0] MODE_IMMEDIATE = 2'd1;
  localparam logic [1:0] MODE_ZEROPAGE  = 2'd2;

  state_t     state_reg, state_next;
  logic [1:0] mode_reg;
  logic       wr_reg;
  logic [7:0] opcode_reg;
  logic [7:0] operand_reg;
  logic [7:0] lo_reg;
  logic [7:0] hi_reg;

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and per-state control outputs, all decoded from the current state.
  always_comb begin
    state_next = state_reg;
    mm         = PC_ADDR;
    pc_inc     = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH_OP;
      end
      FETCH_OP: begin
        pc_inc     = 1'b1;
        state_next = (mode_reg == MODE_IMPLIED) ? DONE : FETCH_LO;
      end
      FETCH_LO: begin
        pc_inc = 1'b1;
        case (mode_reg)
          MODE_IMMEDIATE: state_next = DONE;
          MODE_ZEROPAGE:  state_next = DATA;
          default:        state_next = FETCH_HI;
        endcase
      end
      FETCH_HI: begin
        pc_inc     = 1'b1;
        state_next = DATA;
      end
      DATA: begin
        mm         = OP_ADDR;
        mem_we     = wr_reg;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath captures: request attributes at accept time, fetched bytes as they arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg    <= 2'd0;
      wr_reg      <= 1'b0;
      opcode_reg  <= 8'h00;
      operand_reg <= 8'h00;
      lo_reg      <= 8'h00;
      hi_reg      <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mode_reg <= mode;
            wr_reg   <= wr;
          end
        end
        FETCH_OP: begin
          opcode_reg <= rdata;
          // Zero-page addresses use the same {hi,lo} path, so hi must be zero.
          if (mode_reg == MODE_ZEROPAGE) hi_reg <= 8'h00;
        end
        FETCH_LO: begin
          if (mode_reg == MODE_IMMEDIATE) operand_reg <= rdata;
          else                            lo_reg      <= rdata;
        end
        FETCH_HI: begin
          hi_reg <= rdata;
        end
        DATA: begin
          if (!wr_reg) operand_reg <= rdata;
        end
        default: ;
      endcase
    end
  end

  // Operand address comes only from registers, never straight from rdata.
  assign op_addr = {hi_reg, lo_reg};
  assign opcode  = opcode_reg;
  assign operand = operand_reg;
  assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer: per-cycle control checks for each addressing
// mode, back-to-back operation, ignored inputs mid-sequence and mid-sequence reset.

module tb_mem_sequencer;
  import mem_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic        wr;
  logic [7:0]  rdata;
  mm_t         mm;
  logic        pc_inc;
  logic [15:0] op_addr;
  logic        mem_we;
  logic [7:0]  opcode;
  logic [7:0]  operand;
  logic        busy;
  logic        done;

  int tests_run;
  int tests_failed;

  mem_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .wr      (wr),
    .rdata   (rdata),
    .mm      (mm),
    .pc_inc  (pc_inc),
    .op_addr (op_addr),
    .mem_we  (mem_we),
    .opcode  (opcode),
    .operand (operand),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Run one sequence. b holds the rdata presented in cycle 1..4 after the
  // accepting edge; exp_len is the cycle in which done must be high.
  task automatic run_seq(input string name, input logic [1:0] m, input logic w,
                         input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3,
                         input int exp_len, input logic [7:0] exp_opcode,
                         input logic [7:0] exp_operand, input logic [15:0] exp_addr);
    logic [7:0] b [4];
    int has_data;
    int nfetch;
    int pc_cnt;
    int we_cnt;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    has_data = (m >= 2'd2) ? 1 : 0;
    nfetch   = exp_len - 1 - has_data;
    pc_cnt   = 0;
    we_cnt   = 0;
    @(posedge clk); #1;
    start = 1'b1; mode = m; wr = w;
    @(posedge clk); #1;
    // Scramble request inputs after acceptance; the sequence must not notice.
    start = 1'b0; mode = m ^ 2'b11; wr = ~w; rdata = b[0];
    for (int k = 1; k <= exp_len; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
        rdata = b[(k - 1) & 3];
      end
      @(negedge clk);
      if (pc_inc === 1'b1) pc_cnt++;
      if (mem_we === 1'b1) we_cnt++;
      check({name, "_busy"}, 32'(busy), 32'd1);
      check({name, "_done"}, 32'(done), (k == exp_len) ? 32'd1 : 32'd0);
      check({name, "_pcinc"}, 32'(pc_inc), (k <= nfetch) ? 32'd1 : 32'd0);
      if (has_data == 1 && k == nfetch + 1) begin
        check({name, "_mm_data"}, 32'(mm), 32'(OP_ADDR));
        check({name, "_addr"}, 32'(op_addr), 32'(exp_addr));
        check({name, "_we_data"}, 32'(mem_we), 32'(w));
      end else begin
        check({name, "_mm"}, 32'(mm), 32'(PC_ADDR));
        check({name, "_we"}, 32'(mem_we), 32'd0);
      end
    end
    check({name, "_pc_count"}, 32'(pc_cnt), 32'(nfetch));
    check({name, "_we_count"}, 32'(we_cnt), (has_data == 1 && w) ? 32'd1 : 32'd0);
    check({name, "_opcode"}, 32'(opcode), 32'(exp_opcode));
    check({name, "_operand"}, 32'(operand), 32'(exp_operand));
    check({name, "_op_addr"}, 32'(op_addr), 32'(exp_addr));
    @(posedge clk); #1;
    mode = m; wr = w;
    @(negedge clk);
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    check({name, "_idle_done"}, 32'(done), 32'd0);
    $display("[TB] %s mode=%0d wr=%0d opcode=%02h operand=%02h op_addr=%04h",
             name, m, w, opcode, operand, op_addr);
  endtask

  initial begin
    int done_at [2];
    int ndone;
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; wr = 1'b0; rdata = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pcinc", 32'(pc_inc), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_mm", 32'(mm), 32'(PC_ADDR));
    check("rst_addr", 32'(op_addr), 32'h0);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_operand", 32'(operand), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    // start low in IDLE keeps the block idle
    check("idle_hold", 32'(busy), 32'd0);

    run_seq("implied", 2'd0, 1'b0, 8'hEA, 8'h00, 8'h00, 8'h00, 2, 8'hEA, 8'h00, 16'h0000);
    run_seq("immediate", 2'd1, 1'b0, 8'hA9, 8'h42, 8'h00, 8'h00, 3, 8'hA9, 8'h42, 16'h0000);
    run_seq("zp_read", 2'd2, 1'b0, 8'hA5, 8'h80, 8'h5A, 8'h00, 4, 8'hA5, 8'h5A, 16'h0080);
    run_seq("abs_write", 2'd3, 1'b1, 8'h8D, 8'h34, 8'h12, 8'hFF, 5, 8'h8D, 8'h5A, 16'h1234);
    // hi left at 8'h12 by the absolute access must be cleared for zero page
    run_seq("zp_after_abs", 2'd2, 1'b0, 8'hA5, 8'h10, 8'h77, 8'h00, 4, 8'hA5, 8'h77, 16'h0010);

    // start held high, mode=3: done in cycles 5 and 11 after the first accept edge
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd3; wr = 1'b0; rdata = 8'h11;
    @(posedge clk);
    ndone = 0;
    done_at[0] = 0; done_at[1] = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(posedge clk);
      #1;
      if (k == 2) mode = 2'd0;
      if (k == 4) mode = 2'd3;
      if (k == 11) start = 1'b0;
      @(negedge clk);
      if (done === 1'b1) begin
        if (ndone < 2) done_at[ndone] = k;
        ndone++;
      end
      if (k == 6) check("b2b_idle_gap", 32'(busy), 32'd0);
      if (k == 7) check("b2b_restart", 32'(pc_inc), 32'd1);
    end
    check("b2b_done_count", 32'(ndone), 32'd2);
    check("b2b_done_first", 32'(done_at[0]), 32'd5);
    check("b2b_done_second", 32'(done_at[1]), 32'd11);
    $display("[TB] back_to_back done cycles %0d and %0d", done_at[0], done_at[1]);
    repeat (2) @(negedge clk);
    check("b2b_settle", 32'(busy), 32'd0);

    // Reset in FETCH_HI of an absolute sequence
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd3; wr = 1'b0; rdata = 8'h8D;
    @(posedge clk); #1;
    start = 1'b0; rdata = 8'h8D;
    @(posedge clk); #1;
    rdata = 8'h34;
    @(posedge clk); #2;
    rdata = 8'h12;
    check("pre_rst_pcinc", 32'(pc_inc), 32'd1);
    check("pre_rst_opcode", 32'(opcode), 32'h8D);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pcinc", 32'(pc_inc), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_mm", 32'(mm), 32'(PC_ADDR));
    check("arst_addr", 32'(op_addr), 32'h0);
    check("arst_opcode", 32'(opcode), 32'h0);
    check("arst_operand", 32'(operand), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(done), 32'd0);
    end
    $display("[TB] reset during FETCH_HI aborted sequence");
    run_seq("after_reset", 2'd0, 1'b0, 8'hEA, 8'h00, 8'h00, 8'h00, 2, 8'hEA, 8'h00, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low; ports: clk, rst_n.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  system clock, rising edge
- rst_n  in  1  async active-low reset
- start  in  1  request one access sequence; sampled only in IDLE
- mode  in  2  addressing mode: 0 implied, 1 immediate, 2 zero page, 3 absolute
- wr  in  1  data access is a write (modes 2/3 only)
- rdata  in  8  memory read data, valid combinationally in the cycle the address is driven
- mm  out  mm_t  memory address select to memmux: PC_ADDR or OP_ADDR
- pc_inc  out  1  advance program counter at end of this cycle
- op_addr  out  16  operand address, to memmux addr_in
- mem_we  out  1  memory write strobe
- opcode  out  8  latched opcode byte
- operand  out  8  latched immediate byte or data-read byte
- busy  out  1  sequence in progress (state not IDLE)
- done  out  1  one-cycle completion pulse

Function
REQ-003 The FSM SHALL have states IDLE, FETCH_OP, FETCH_LO, FETCH_HI, DATA, DONE; one transition per clock.
REQ-004 In IDLE with start=1, the block SHALL latch mode and wr into internal registers and go to FETCH_OP; with start=0 it stays in IDLE.
REQ-005 start SHALL be ignored in every state other than IDLE; no queuing.
REQ-006 FETCH_OP: mm=PC_ADDR, pc_inc=1, opcode<=rdata at end of cycle; next state DONE if latched mode=0, else FETCH_LO.
REQ-007 FETCH_LO: mm=PC_ADDR, pc_inc=1; mode 1: operand<=rdata, next DONE; mode 2: lo<=rdata, next DATA; mode 3: lo<=rdata, next FETCH_HI.
REQ-008 FETCH_HI: mm=PC_ADDR, pc_inc=1, hi<=rdata, next DATA.
REQ-009 DATA: mm=OP_ADDR, pc_inc=0; op_addr={8'h00,lo} for mode 2, {hi,lo} for mode 3; mem_we=latched wr; on read (wr=0), operand<=rdata; on write, operand unchanged; next DONE.
REQ-010 DONE: done=1 for exactly this cycle, mm=PC_ADDR, next IDLE.
REQ-011 op_addr SHALL be driven from registered lo/hi in all states (no combinational path from rdata); hi SHALL be cleared to 8'h00 when a mode-2 sequence enters FETCH_LO.
REQ-012 Outside DATA, mm SHALL be PC_ADDR and mem_we SHALL be 0; pc_inc SHALL be 1 only in FETCH_OP/FETCH_LO/FETCH_HI.
REQ-013 Latency from the start-sampling edge to the done cycle SHALL be: mode 0: 2 cycles, mode 1: 3, mode 2: 4, mode 3: 5; start may be reasserted in the cycle after DONE (IDLE), giving back-to-back sequences with one IDLE cycle.
REQ-014 busy SHALL equal (state != IDLE), including the DONE cycle.
REQ-015 Changes on mode/wr after sampling SHALL NOT affect the running sequence.

Reset
REQ-016 On rst_n=0, asynchronously: state=IDLE, opcode=8'h00, operand=8'h00, lo=hi=8'h00, done=0, busy=0, pc_inc=0, mem_we=0, mm=PC_ADDR, op_addr=16'h0000.
REQ-017 Reset asserted mid-sequence SHALL abort it immediately with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-018 Implied: start, mode=0, rdata=8'hEA in FETCH_OP -> opcode=8'hEA, pc_inc high 1 cycle, done 2 cycles after start edge, mem_we never 1.
REQ-019 Immediate: mode=1, rdata 8'hA9 then 8'h42 -> opcode=8'hA9, operand=8'h42, pc_inc high 2 cycles, done at cycle 3.
REQ-020 Zero-page read: mode=2, wr=0, rdata 8'hA5, 8'h80, 8'h5A -> DATA cycle has mm=OP_ADDR, op_addr=16'h0080, mem_we=0; operand=8'h5A; done at cycle 4.
REQ-021 Absolute write: mode=3, wr=1, rdata 8'h8D, 8'h34, 8'h12 -> DATA cycle op_addr=16'h1234, mm=OP_ADDR, mem_we=1 for exactly one cycle, pc_inc high 3 cycles, done at cycle 5.
REQ-022 start held high continuously with mode=3 -> sequences repeat every 6 cycles; start pulses during FETCH_HI ignored; mode toggled to 0 mid-sequence has no effect.
REQ-023 rst_n pulsed low during FETCH_HI of an absolute sequence -> outputs take reset values asynchronously, no done pulse, next start with mode=0 completes in 2 cycles.
